// File: rtl/proc_pkg.sv
// Shared processor definitions: MIPS memory opcodes plus small decode helpers
// used by the memory stage, the decoder and ALU control.
package proc_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_t;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } mem_state_t;

    // Access width of a memory opcode; SZ_NONE marks an illegal opcode.
    function automatic access_size_t access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: access_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: access_size = SZ_HALF;
            OP_LW, OP_SW:         access_size = SZ_WORD;
            default:              access_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword from a read word and sign- or
// zero-extends it to 32 bits according to the load opcode.
module load_extend
    import proc_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [5:0]  opcode,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension; non-load opcodes produce zero.
    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (opcode)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h000000, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0000, half_sel};
            OP_LW:   result = word;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory_bus.sv
// Byte-addressed DEPTH x 32-bit data memory for the MEM stage. Valid/ready
// request port, fixed one-cycle registered response, error flag for illegal
// accesses, and a clear sweep that zeroes the array after reset.
module data_memory_bus
    import proc_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int IDX_W          = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    mem_state_t       state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic             ready_reg;

    logic             accept;
    logic             clearing;
    access_size_t     size;
    logic             out_of_range;
    logic             misaligned;
    logic             req_err;
    logic             do_store;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] ram_idx;
    logic [3:0]       store_be;
    logic [31:0]      store_data;
    logic [3:0]       lane_we;
    logic [31:0]      lane_wdata;
    logic [31:0]      rd_word;

    logic             rsp_valid_reg;
    logic             rsp_err_reg;
    logic             rsp_load_reg;
    logic [5:0]       rsp_op_reg;
    logic [1:0]       rsp_lane_reg;
    logic [31:0]      ext_data;

    assign accept   = req_valid && ready_reg;
    assign clearing = (state_reg == ST_CLEAR);
    assign req_idx  = addr[IDX_W+1:2];

    // Request decode: legality checks and store lane enables / lane data.
    always_comb begin
        size         = access_size(opcode);
        out_of_range = (addr >> (IDX_W + 2)) != 32'd0;
        misaligned   = 1'b0;
        store_be     = 4'b0000;
        store_data   = wdata;
        case (size)
            SZ_BYTE: begin
                store_be   = 4'b0001 << addr[1:0];
                store_data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                misaligned = addr[0];
                store_be   = addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                misaligned = (addr[1:0] != 2'b00);
                store_be   = 4'b1111;
            end
            default: ;
        endcase
        req_err  = (size == SZ_NONE) || out_of_range || misaligned;
        do_store = accept && !req_err && is_store(opcode);
    end

    // RAM port mux: the clear sweep owns the write port until RUN.
    always_comb begin
        ram_idx    = clearing ? cnt_reg : req_idx;
        lane_we    = clearing ? 4'b1111 : (do_store ? store_be : 4'b0000);
        lane_wdata = clearing ? 32'h0000_0000 : store_data;
    end

    // One byte-wide RAM per lane keeps byte writes independent and lets
    // each lane map onto its own block RAM with a registered read.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rd_byte;

            // Lane write (sweep or store) and registered read of the same index.
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem_lane[ram_idx] <= lane_wdata[gi*8 +: 8];
                end
                rd_byte <= mem_lane[ram_idx];
            end

            assign rd_word[gi*8 +: 8] = rd_byte;
        end
    endgenerate

    // Clear FSM next-state: sweep every word once, then serve requests.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN:  ;
            default: state_next = ST_CLEAR;
        endcase
    end

    // Clear FSM state, sweep counter and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= (state_next == ST_RUN);
        end
    end

    // Response pipeline: capture what is needed to shape rdata next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_load_reg  <= 1'b0;
            rsp_op_reg    <= 6'd0;
            rsp_lane_reg  <= 2'd0;
        end else begin
            rsp_valid_reg <= accept;
            rsp_err_reg   <= accept && req_err;
            rsp_load_reg  <= accept && !req_err && !is_store(opcode);
            rsp_op_reg    <= opcode;
            rsp_lane_reg  <= addr[1:0];
        end
    end

    load_extend u_load_extend (
        .word   (rd_word),
        .lane   (rsp_lane_reg),
        .opcode (rsp_op_reg),
        .result (ext_data)
    );

    assign req_ready = ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rdata     = rsp_load_reg ? ext_data : 32'h0000_0000;

endmodule

// File: tb/tb_data_memory_bus.sv
// Randomised plus directed bench for data_memory_bus against a byte-array
// reference model of the memory.
module tb_data_memory_bus;
    import proc_pkg::*;

    localparam int DEPTH = 256;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  model [BYTES];
    logic [31:0] last_rdata;
    logic        last_err;

    data_memory_bus #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .opcode    (opcode),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    // Reference behaviour: bytes in a flat array, little-endian.
    task automatic model_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                                output logic err, output logic [31:0] val);
        int sz;
        sz  = op_size(op);
        val = 32'd0;
        err = (sz == 0) || (a >= 32'(BYTES));
        if (!err) err = (int'(a) % sz) != 0;
        if (!err) begin
            if (op == OP_SB || op == OP_SH || op == OP_SW) begin
                for (int i = 0; i < sz; i++) model[int'(a) + i] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) val = val | (32'(model[int'(a) + i]) << (8 * i));
                if (op == OP_LB && val[7])  val = val | 32'hFFFF_FF00;
                if (op == OP_LH && val[15]) val = val | 32'hFFFF_0000;
            end
        end
    endtask

    // Issue one request at a negedge; check its response one cycle later.
    task automatic txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d, input string tag);
        logic        e;
        logic [31:0] v;
        model_access(op, a, d, e, v);
        req_valid = 1'b1;
        opcode    = op;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        last_rdata = rdata;
        last_err   = rsp_err;
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".err"},   32'(rsp_err),   32'(e));
        check({tag, ".rdata"}, rdata,          v);
        $display("txn %-10s op=%b addr=0x%08h wdata=0x%08h -> err=%0b rdata=0x%08h",
                 tag, op, a, d, rsp_err, rdata);
    endtask

    task automatic idle_cycle(input string tag);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd0);
        $display("txn %-10s idle -> rsp_valid=%0b", tag, rsp_valid);
    endtask

    // Hold reset, release at a negedge, measure the not-ready period.
    task automatic reset_and_sweep(input string tag);
        int n;
        req_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < BYTES; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check({tag, ".rst_ready"}, 32'(req_ready), 32'd0);
        check({tag, ".rst_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".rst_rdata"}, rdata, 32'd0);
        rst = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check({tag, ".sweep_len"}, 32'(n), 32'(DEPTH));
        $display("txn %-10s reset sweep -> not-ready cycles=%0d", tag, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  ops [8];
        logic [5:0]  op;
        logic [31:0] a;
        int          sz;
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        reset_and_sweep("por");
        txn(OP_LW, 32'h000, 32'h0, "lw000");
        txn(OP_LW, 32'h3FC, 32'h0, "lw3fc");

        txn(OP_SW,  32'h10, 32'hDEADBEEF, "sw10");
        txn(OP_LW,  32'h10, 32'h0,        "lw10");
        check("plan.lw10", last_rdata, 32'hDEADBEEF);
        txn(OP_SB,  32'h13, 32'h0000_0080, "sb13");
        txn(OP_LB,  32'h13, 32'h0, "lb13");
        check("plan.lb13", last_rdata, 32'hFFFFFF80);
        txn(OP_LBU, 32'h13, 32'h0, "lbu13");
        check("plan.lbu13", last_rdata, 32'h00000080);
        txn(OP_LW,  32'h10, 32'h0, "lw10b");
        check("plan.lw10b", last_rdata, 32'h80ADBEEF);
        txn(OP_SH,  32'h22, 32'h0000_1234, "sh22");
        txn(OP_LHU, 32'h22, 32'h0, "lhu22");
        check("plan.lhu22", last_rdata, 32'h00001234);
        txn(OP_LH,  32'h20, 32'h0, "lh20");
        check("plan.lh20", last_rdata, 32'h00000000);
        txn(OP_LW,  32'h20, 32'h0, "lw20");
        check("plan.lw20", last_rdata, 32'h12340000);

        txn(OP_LW,   32'h11,  32'h0,         "e_lw11");
        check("plan.e_lw11", 32'(last_err), 32'd1);
        txn(OP_LW,   32'h10,  32'h0,         "re_lw10");
        txn(OP_SH,   32'h21,  32'h0000_FFFF, "e_sh21");
        check("plan.e_sh21", 32'(last_err), 32'd1);
        txn(OP_LW,   32'h20,  32'h0,         "re_lw20");
        txn(OP_SW,   32'h400, 32'hFFFF_FFFF, "e_sw400");
        check("plan.e_sw400", 32'(last_err), 32'd1);
        txn(OP_LW,   32'h000, 32'h0,         "re_lw000");
        txn(6'b000000, 32'h10, 32'h0,        "e_op0");
        check("plan.e_op0", 32'(last_err), 32'd1);
        txn(OP_LW,   32'h10,  32'h0,         "re_lw10b");
        idle_cycle("idle0");
        idle_cycle("idle1");

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle_cycle("rnd_idle");
            end else begin
                op = ops[$urandom_range(0, 7)];
                if ($urandom_range(0, 15) == 0) op = 6'($urandom);
                a  = 32'($urandom_range(0, 127));
                sz = op_size(op);
                if (sz != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
                if ($urandom_range(0, 19) == 0) a = $urandom | 32'h400;
                txn(op, a, $urandom, "rnd");
            end
        end

        // Reset in the middle of the clear sweep.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid.ready", 32'(req_ready), 32'd0);
        reset_and_sweep("midsweep");

        // Reset while a load response is pending.
        txn(OP_SW, 32'h40, 32'hCAFEF00D, "sw40");
        req_valid = 1'b1;
        opcode    = OP_LW;
        addr      = 32'h40;
        wdata     = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort.valid", 32'(rsp_valid), 32'd0);
        check("abort.rdata", rdata, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort.valid2", 32'(rsp_valid), 32'd0);
        reset_and_sweep("abort");
        txn(OP_LW, 32'h40, 32'h0, "lw40");
        check("plan.lw40", last_rdata, 32'h00000000);
        idle_cycle("idle_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/data_memory_bus.md
Name: data_memory_bus

Overview:
- Parametrised successor data memory for the soft processor's MEM stage: byte-addressed, DEPTH x 32-bit words.
- Supports MIPS LB/LBU/LH/LHU/LW/SB/SH/SW with byte-lane writes and sign/zero-extended loads.
- Valid/ready request port with fixed 1-cycle registered response and an error flag for misaligned, out-of-range or illegal accesses.
- A post-reset clear FSM zeroes the whole array before the first request is accepted.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 4.
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after every reset; 0 = skip it and go ready immediately.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- opcode  in  6  MIPS opcode: LB=100000, LH=100001, LW=100011, LBU=100100, LHU=100101, SB=101000, SH=101001, SW=101011.
- addr  in  32  byte address.
- wdata  in  32  store data (Rt); low byte/half used for SB/SH.
- rsp_valid  out  1  one-cycle pulse; response for the request accepted in the previous cycle.
- rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: access rejected.

Behaviour:
- Reset (async assert): req_ready=0, rsp_valid=0, rdata=0, rsp_err=0, clear counter=0. State goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
- States:
  - CLEAR: writes 0 to word[cnt] each cycle, cnt increments; req_ready=0. When cnt=DEPTH-1 is written, go to RUN on the same edge. Sweep takes exactly DEPTH cycles.
  - RUN: req_ready=1 every cycle, no backpressure; throughput one request per cycle.
- Reset asserted mid-sweep or mid-access: abort, drop any pending response, restart the sweep from 0.
- Accept condition: req_valid && req_ready at posedge N. The response appears with rsp_valid=1 after edge N+1's setup, i.e. in cycle N+1; rsp_valid is low in every cycle with no accepted request.
- Word index: addr[IDX_W+1:2]; byte lane: addr[1:0].
- Error cases give rsp_err=1, rdata=0 and no memory change:
  - addr[31:IDX_W+2] != 0 (out of range).
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0] != 0.
  - Opcode not in the list above.
- Stores: write at posedge N, only the enabled lanes.
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} get wdata[15:0], little-endian.
  - SW: all lanes.
  - Response in cycle N+1: rsp_valid=1, rsp_err=0, rdata=0.
- Loads: word read registered at posedge N; lane select and extension produce rdata in cycle N+1.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW returns the full word.
- Store at N followed by load of the same word at N+1: the load returns the new data, with no stall.
- A partial store leaves untouched lanes unchanged.

Decomposition:
- Shared package `proc_pkg`: the eight opcode localparams, shared with the decoder and ALU control.
- Sub-module `load_extend`: combinational; takes word, addr[1:0] and opcode, returns the extended 32-bit result.
- Storage, clear FSM and handshake stay in `data_memory_bus`.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH=256 -> req_ready=0 for exactly 256 cycles, then 1. LW from 0x000 and 0x3FC -> rdata=0, rsp_err=0.
- SW 0xDEADBEEF to 0x10, then LW 0x10 on the next cycle -> rdata=0xDEADBEEF in the cycle after the load is accepted, back-to-back with no gap.
- SB 0x80 to 0x13, then:
  - LB 0x13 -> 0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LW 0x10 -> 0x80ADBEEF.
- SH 0x1234 to 0x22, then:
  - LHU 0x22 -> 0x00001234.
  - LH 0x20 -> 0x00000000.
  - LW 0x20 -> 0x12340000.
- Errors, each giving rsp_err=1, rdata=0 and memory unchanged on re-read:
  - LW 0x11.
  - SH 0x21.
  - SW 0x400 with DEPTH=256.
  - Opcode 000000.
- Reset asserted 10 cycles into the sweep and during a pending load response -> rsp_valid drops immediately, and the sweep restarts with a full 256-cycle req_ready=0 period.
